edge_seq_ctrl: RTL and testbench
================================

# edge_seq_ctrl

Parametrised frame-level sequencer for the edge-detection datapath, the multi-bank successor of the single-row main controller. Rotates row buffers through `NUM_BANKS` banks and primes the first `NUM_BANKS-1` rows without computing, so the kernel always sees a full row window. Each subsequent row is read, computed for a fixed number of cycles, and written back. Sits between the read/write bus masters and the Sobel calculation unit, and adds watchdog timeouts, abort and frame-level done/error reporting.

## Interface
- `NUM_BANKS`, 3, number of row buffer banks (3..4); kernel height equals `NUM_BANKS`
- `ROW_W`, 10, width of row counters
- `CALC_CYCLES`, 16, cycles `enable_calc` stays high per computed row (≥1)
- `TIMEOUT`, 1023, max cycles spent waiting in READ or WRITE (≥1)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin frame; sampled only in IDLE
- `abort`  in  1  return to IDLE next cycle from any state
- `frame_rows`  in  ROW_W  input rows in the frame; latched on accepted `start`
- `load_enable_r`  in  1  read master has a row available
- `transfer_data_complete_r`  in  1  one-cycle pulse: row read into `fill_bank` done
- `transfer_data_complete_w`  in  1  one-cycle pulse: result row written back
- `buffer_clear`  out  1  clear bank `fill_bank` this cycle
- `start_read`  out  1  one-cycle pulse launching the row read
- `enable_calc`  out  1  calculation enable
- `start_write`  out  1  one-cycle pulse launching the write-back
- `fill_bank`  out  BANK_W  bank being cleared or filled; BANK_W = $clog2(NUM_BANKS)
- `calc_bank`  out  BANK_W  oldest bank (top row of window) = (fill_bank+1) mod NUM_BANKS
- `busy`  out  1  high in every state except IDLE and ERR
- `frame_done`  out  1  one-cycle pulse at end of frame
- `error`  out  1  high while in ERR

## Operation
- States: IDLE, CLEAR, WAIT_LD, READ, CALC, WRITE, DONE, ERR. All outputs are decoded from registered state and counters.
- IDLE: `start`=1 with `frame_rows` < NUM_BANKS → ERR. Otherwise latch rows, row_cnt=0, fill_bank=0 → CLEAR.
- CLEAR: `buffer_clear`=1 for exactly one cycle → WAIT_LD.
- WAIT_LD: `load_enable_r`=1 → READ. No timeout in this state.
- READ: `start_read`=1 in the first READ cycle only. On `transfer_data_complete_r`:
  - row_cnt < NUM_BANKS-1 (priming) → ADVANCE.
  - otherwise → CALC.
- CALC: `enable_calc`=1 for exactly CALC_CYCLES consecutive cycles → WRITE.
- WRITE: `start_write`=1 in the first WRITE cycle. On `transfer_data_complete_w` → ADVANCE.
- ADVANCE (a transition action, not a state):
  - row_cnt += 1 and fill_bank = (fill_bank+1) mod NUM_BANKS.
  - If the new row_cnt == latched rows → DONE, else → CLEAR.
- DONE: `frame_done`=1 for one cycle → IDLE.
- Watchdog: counts cycles in READ/WRITE and restarts on entry to either state. Reaching TIMEOUT without the completion pulse → ERR.
- ERR: `error`=1. Leaves only via `abort` or `rst`; `start` is ignored.
- Completion pulses outside their waiting state are ignored.
- Computed rows per frame = frame_rows − (NUM_BANKS−1).

## Timing
- Reset: state IDLE; all outputs 0; fill_bank=0, calc_bank=1; counters 0.
- `start` high at edge N → `buffer_clear` high in cycle N+1, `busy` high from N+1.
- `load_enable_r` seen at edge M → `start_read` high in cycle M+1.
- Completion pulse at edge K → `enable_calc` high in cycles K+1 .. K+CALC_CYCLES; `start_write` in cycle K+CALC_CYCLES+1.
- Last write complete at edge L → `frame_done` in cycle L+1; `busy` low from L+2.
- Simultaneous events:
  - `abort` beats everything.
  - A completion pulse beats a watchdog expiry in the same cycle.
  - `rst` mid-frame returns to reset values immediately (asynchronous).
- fill_bank wraps from NUM_BANKS−1 to 0. row_cnt never wraps, since rows < 2^ROW_W.

## Structure
- Package `edge_ctrl_pkg`: state enum typedef `edge_state_t`, `BANK_W` helper function, default CALC_CYCLES/TIMEOUT constants.
- Sub-module `edge_watchdog`: a loadable down-counter with `clear`, `run` and an `expired` output, instantiated once.
- The top holds the FSM, row/bank counters and the calc counter.

## Test plan
(NUM_BANKS=3, CALC_CYCLES=4, TIMEOUT=8 unless stated.)
- Nominal frame, frame_rows=4:
  - Rows 0,1 produce no `enable_calc`.
  - Rows 2,3 each give 4 cycles of `enable_calc` and one `start_write`.
  - fill_bank sequence is 0,1,2,0.
  - One `frame_done`, then `busy`=0.
- frame_rows=2 at `start` → `error`=1 next cycle, `busy`=0, no `buffer_clear`; `abort` → IDLE.
- Read timeout: no `transfer_data_complete_r` for 8 cycles in READ → `error`=1. A pulse in the 8th cycle instead → CALC, no error.
- `abort` during CALC cycle 2 → next cycle `enable_calc`=0, IDLE. A fresh `start` restarts with fill_bank=0.
- Stray `transfer_data_complete_w` during READ is ignored; later `rst` pulse mid-WRITE gives all outputs 0 the same cycle.
- NUM_BANKS=4, frame_rows=5: `calc_bank` = (fill_bank+1) mod 4 throughout; exactly 2 computed rows.

Source files
------------

// File: rtl/edge_ctrl_pkg.sv
// Shared types and constants for the multi-bank edge-detection frame sequencer.
package edge_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StWaitLd,
      StRead,
      StCalc,
      StWrite,
      StDone,
      StErr
   } edge_state_t;

   localparam int unsigned DEF_CALC_CYCLES = 16;
   localparam int unsigned DEF_TIMEOUT     = 1023;

   function automatic int unsigned bank_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter holding 0 .. n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/edge_seq_ctrl_if.sv
// Handshake bundle between the frame sequencer and the bus masters / Sobel unit.
interface edge_seq_ctrl_if
   import edge_ctrl_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 3,
   parameter int unsigned ROW_W     = 10
);

   localparam int unsigned BANK_W = bank_w(NUM_BANKS);

   logic              i_start;
   logic              i_abort;
   logic [ROW_W-1:0]  i_frame_rows;
   logic              i_load_enable_r;
   logic              i_transfer_data_complete_r;
   logic              i_transfer_data_complete_w;
   logic              o_buffer_clear;
   logic              o_start_read;
   logic              o_enable_calc;
   logic              o_start_write;
   logic [BANK_W-1:0] o_fill_bank;
   logic [BANK_W-1:0] o_calc_bank;
   logic              o_busy;
   logic              o_frame_done;
   logic              o_error;

   modport master (
      input  i_start, i_abort, i_frame_rows, i_load_enable_r,
             i_transfer_data_complete_r, i_transfer_data_complete_w,
      output o_buffer_clear, o_start_read, o_enable_calc, o_start_write,
             o_fill_bank, o_calc_bank, o_busy, o_frame_done, o_error
   );

   modport slave (
      output i_start, i_abort, i_frame_rows, i_load_enable_r,
             i_transfer_data_complete_r, i_transfer_data_complete_w,
      input  o_buffer_clear, o_start_read, o_enable_calc, o_start_write,
             o_fill_bank, o_calc_bank, o_busy, o_frame_done, o_error
   );

endinterface

// File: rtl/edge_watchdog.sv
// Loadable down-counter flagging when a READ/WRITE wait has lasted TIMEOUT cycles.
module edge_watchdog
   import edge_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expired
);

   localparam int unsigned CNT_W = cnt_w(TIMEOUT);

   logic [CNT_W-1:0] r_cnt;

   // Loaded with TIMEOUT-1 so that the TIMEOUT-th waiting cycle sees zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= CNT_W'(TIMEOUT - 1);
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/edge_seq_ctrl.sv
// Frame sequencer: rotates row banks, primes NUM_BANKS-1 rows, then read/calc/write per row.
module edge_seq_ctrl
   import edge_ctrl_pkg::*;
#(
   parameter int unsigned NUM_BANKS   = 3,
   parameter int unsigned ROW_W       = 10,
   parameter int unsigned CALC_CYCLES = DEF_CALC_CYCLES,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
   input logic             clk,
   input logic             rst,
   edge_seq_ctrl_if.master if_ctrl
);

   localparam int unsigned BANK_W = bank_w(NUM_BANKS);
   localparam int unsigned CALC_W = cnt_w(CALC_CYCLES);

   edge_state_t       r_state;
   logic [ROW_W-1:0]  r_rows;
   logic [ROW_W-1:0]  r_row_cnt;
   logic [BANK_W-1:0] r_fill_bank;
   logic [BANK_W-1:0] r_calc_bank;
   logic [CALC_W-1:0] r_calc_cnt;
   logic              r_buffer_clear;
   logic              r_start_read;
   logic              r_enable_calc;
   logic              r_start_write;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_error;

   logic [ROW_W-1:0]  w_row_next;
   logic [BANK_W-1:0] w_fill_next;
   logic [BANK_W-1:0] w_calc_next;
   logic              w_last_row;
   logic              w_priming;
   logic              w_wd_run;
   logic              w_wd_expired;

   assign w_row_next  = r_row_cnt + ROW_W'(1);
   assign w_fill_next = (r_fill_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : r_fill_bank + BANK_W'(1);
   assign w_calc_next = (r_calc_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : r_calc_bank + BANK_W'(1);
   assign w_last_row  = (w_row_next == r_rows);
   assign w_priming   = (r_row_cnt < ROW_W'(NUM_BANKS - 1));
   assign w_wd_run    = (r_state == StRead) || (r_state == StWrite);

   // Held loaded outside READ/WRITE, so each entry into either state restarts the count.
   edge_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (!w_wd_run),
      .i_run     (w_wd_run),
      .o_expired (w_wd_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= StIdle;
         r_rows         <= '0;
         r_row_cnt      <= '0;
         r_fill_bank    <= '0;
         r_calc_bank    <= BANK_W'(1);
         r_calc_cnt     <= '0;
         r_buffer_clear <= 1'b0;
         r_start_read   <= 1'b0;
         r_enable_calc  <= 1'b0;
         r_start_write  <= 1'b0;
         r_busy         <= 1'b0;
         r_frame_done   <= 1'b0;
         r_error        <= 1'b0;
      end else begin
         r_buffer_clear <= 1'b0;
         r_start_read   <= 1'b0;
         r_start_write  <= 1'b0;
         r_frame_done   <= 1'b0;
         if (if_ctrl.i_abort) begin
            r_state       <= StIdle;
            r_enable_calc <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
         end else begin
            case (r_state)
               StIdle: begin
                  if (if_ctrl.i_start) begin
                     if (if_ctrl.i_frame_rows < ROW_W'(NUM_BANKS)) begin
                        r_state <= StErr;
                        r_error <= 1'b1;
                     end else begin
                        r_rows         <= if_ctrl.i_frame_rows;
                        r_row_cnt      <= '0;
                        r_fill_bank    <= '0;
                        r_calc_bank    <= BANK_W'(1);
                        r_buffer_clear <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= StClear;
                     end
                  end
               end
               StClear: r_state <= StWaitLd;
               StWaitLd: begin
                  if (if_ctrl.i_load_enable_r) begin
                     r_state      <= StRead;
                     r_start_read <= 1'b1;
                  end
               end
               StRead: begin
                  // Completion wins over a watchdog expiry in the same cycle.
                  if (if_ctrl.i_transfer_data_complete_r) begin
                     if (w_priming) begin
                        r_row_cnt   <= w_row_next;
                        r_fill_bank <= w_fill_next;
                        r_calc_bank <= w_calc_next;
                        if (w_last_row) begin
                           r_state      <= StDone;
                           r_frame_done <= 1'b1;
                        end else begin
                           r_state        <= StClear;
                           r_buffer_clear <= 1'b1;
                        end
                     end else begin
                        r_state       <= StCalc;
                        r_enable_calc <= 1'b1;
                        r_calc_cnt    <= '0;
                     end
                  end else if (w_wd_expired) begin
                     r_state <= StErr;
                     r_busy  <= 1'b0;
                     r_error <= 1'b1;
                  end
               end
               StCalc: begin
                  if (r_calc_cnt == CALC_W'(CALC_CYCLES - 1)) begin
                     r_state       <= StWrite;
                     r_enable_calc <= 1'b0;
                     r_start_write <= 1'b1;
                  end else begin
                     r_calc_cnt <= r_calc_cnt + CALC_W'(1);
                  end
               end
               StWrite: begin
                  if (if_ctrl.i_transfer_data_complete_w) begin
                     r_row_cnt   <= w_row_next;
                     r_fill_bank <= w_fill_next;
                     r_calc_bank <= w_calc_next;
                     if (w_last_row) begin
                        r_state      <= StDone;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_state        <= StClear;
                        r_buffer_clear <= 1'b1;
                     end
                  end else if (w_wd_expired) begin
                     r_state <= StErr;
                     r_busy  <= 1'b0;
                     r_error <= 1'b1;
                  end
               end
               StDone: begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end
               StErr: r_state <= StErr;
            endcase
         end
      end
   end

   assign if_ctrl.o_buffer_clear = r_buffer_clear;
   assign if_ctrl.o_start_read   = r_start_read;
   assign if_ctrl.o_enable_calc  = r_enable_calc;
   assign if_ctrl.o_start_write  = r_start_write;
   assign if_ctrl.o_fill_bank    = r_fill_bank;
   assign if_ctrl.o_calc_bank    = r_calc_bank;
   assign if_ctrl.o_busy         = r_busy;
   assign if_ctrl.o_frame_done   = r_frame_done;
   assign if_ctrl.o_error        = r_error;

endmodule

// File: tb/tb_edge_seq_ctrl.sv
// Randomized bench: builds per-cycle stimulus and expected outputs from a frame-schedule model.
module tb_edge_seq_ctrl;

   typedef struct packed {
      logic       rst;
      logic       start;
      logic       abort;
      logic [9:0] rows;
      logic       ld;
      logic       cr;
      logic       cw;
   } stim_t;

   typedef struct {
      bit bc, sr, ec, sw, busy, fd, err;
      int fill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   edge_seq_ctrl_if #(.NUM_BANKS(3), .ROW_W(10)) b3 ();
   edge_seq_ctrl_if #(.NUM_BANKS(4), .ROW_W(10)) b4 ();

   edge_seq_ctrl #(
      .NUM_BANKS(3), .ROW_W(10), .CALC_CYCLES(4), .TIMEOUT(8)
   ) u_dut3 (
      .clk     (clk),
      .rst     (rst),
      .if_ctrl (b3)
   );

   edge_seq_ctrl #(
      .NUM_BANKS(4), .ROW_W(10), .CALC_CYCLES(4), .TIMEOUT(8)
   ) u_dut4 (
      .clk     (clk),
      .rst     (rst),
      .if_ctrl (b4)
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   int    m_nb     = 3;
   int    m_cc     = 4;
   int    m_to     = 8;
   int    m_fill   = 0;
   int    mark_calc2;
   int    mark_write;
   int    n_sw4;
   stim_t stim_q[$];
   exp_t  exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic stim_t noise(input bit a_cr, input bit a_cw, input bit a_ld, input bit a_st);
      stim_t s;
      s       = '0;
      s.rows  = 10'($urandom_range(0, 9));
      s.cr    = a_cr && ($urandom_range(0, 3) == 0);
      s.cw    = a_cw && ($urandom_range(0, 3) == 0);
      s.ld    = a_ld && ($urandom_range(0, 3) == 0);
      s.start = a_st && ($urandom_range(0, 3) == 0);
      return s;
   endfunction

   task automatic push(input stim_t s, input bit bc, input bit sr, input bit ec, input bit sw,
                       input bit busy, input bit fd, input bit err);
      exp_t e;
      e.bc = bc; e.sr = sr; e.ec = ec; e.sw = sw;
      e.busy = busy; e.fd = fd; e.err = err; e.fill = m_fill;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // bank window rule: top row bank is one past the fill bank
   function automatic logic [10:0] exp_vec(input exp_t e);
      return {e.bc, e.sr, e.ec, e.sw, 2'(e.fill), 2'((e.fill + 1) % m_nb), e.busy, e.fd, e.err};
   endfunction

   function automatic logic [10:0] obs_vec(input int sel);
      if (sel == 0)
         return {b3.o_buffer_clear, b3.o_start_read, b3.o_enable_calc, b3.o_start_write,
                 b3.o_fill_bank, b3.o_calc_bank, b3.o_busy, b3.o_frame_done, b3.o_error};
      return {b4.o_buffer_clear, b4.o_start_read, b4.o_enable_calc, b4.o_start_write,
              b4.o_fill_bank, b4.o_calc_bank, b4.o_busy, b4.o_frame_done, b4.o_error};
   endfunction

   task automatic drive(input int sel, input stim_t s);
      stim_t z;
      stim_t a;
      stim_t b;
      z = '0;
      a = (sel == 0) ? s : z;
      b = (sel == 1) ? s : z;
      b3.i_start = a.start; b3.i_abort = a.abort; b3.i_frame_rows = a.rows;
      b3.i_load_enable_r = a.ld; b3.i_transfer_data_complete_r = a.cr;
      b3.i_transfer_data_complete_w = a.cw;
      b4.i_start = b.start; b4.i_abort = b.abort; b4.i_frame_rows = b.rows;
      b4.i_load_enable_r = b.ld; b4.i_transfer_data_complete_r = b.cr;
      b4.i_transfer_data_complete_w = b.cw;
   endtask

   task automatic idle(input int n);
      repeat (n) push(noise(1, 1, 1, 0), 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic err_hold(input int n);
      repeat (n) push(noise(1, 1, 1, 1), 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic push_abort();
      stim_t s;
      s       = noise(1, 1, 1, 1);
      s.start = 1'b1;
      s.rows  = 10'd5;
      s.abort = 1'b1;
      push(s, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push_reset();
      stim_t s;
      s      = '0;
      s.rst  = 1'b1;
      m_fill = 0;
      push(s, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic trunc(input int n);
      while (stim_q.size() > n) begin
         void'(stim_q.pop_back());
         void'(exp_q.pop_back());
      end
      m_fill = exp_q[exp_q.size() - 1].fill;
   endtask

   // One frame as a schedule of row phases; to_row selects a row whose read never completes.
   task automatic build_frame(input int rows, input int force_dr, input int to_row);
      stim_t s;
      int    d;
      mark_calc2 = -1;
      mark_write = -1;
      s       = noise(1, 1, 1, 0);
      s.start = 1'b1;
      s.rows  = 10'(rows);
      if (rows < m_nb) begin
         push(s, 0, 0, 0, 0, 0, 0, 1);
         return;
      end
      m_fill = 0;
      push(s, 1, 0, 0, 0, 1, 0, 0);
      for (int r = 0; r < rows; r++) begin
         push(noise(1, 1, 1, 1), 0, 0, 0, 0, 1, 0, 0);
         d = $urandom_range(0, 3);
         repeat (d) push(noise(1, 1, 0, 1), 0, 0, 0, 0, 1, 0, 0);
         s    = noise(1, 1, 0, 1);
         s.ld = 1'b1;
         push(s, 0, 1, 0, 0, 1, 0, 0);
         if (r == to_row) begin
            repeat (m_to - 1) push(noise(0, 1, 1, 1), 0, 0, 0, 0, 1, 0, 0);
            push(noise(0, 1, 1, 1), 0, 0, 0, 0, 0, 0, 1);
            return;
         end
         d = (force_dr >= 0) ? force_dr : $urandom_range(0, m_to - 1);
         repeat (d) push(noise(0, 1, 1, 1), 0, 0, 0, 0, 1, 0, 0);
         s    = noise(0, 1, 1, 1);
         s.cr = 1'b1;
         if (r < m_nb - 1) begin
            m_fill = (m_fill + 1) % m_nb;
            push(s, 1, 0, 0, 0, 1, 0, 0);
            continue;
         end
         push(s, 0, 0, 1, 0, 1, 0, 0);
         for (int c = 2; c <= m_cc; c++) begin
            push(noise(1, 1, 1, 1), 0, 0, 1, 0, 1, 0, 0);
            if (c == 2 && mark_calc2 < 0) mark_calc2 = stim_q.size() - 1;
         end
         push(noise(1, 1, 1, 1), 0, 0, 0, 1, 1, 0, 0);
         if (mark_write < 0) mark_write = stim_q.size() - 1;
         d = $urandom_range(0, m_to - 1);
         repeat (d) push(noise(1, 0, 1, 1), 0, 0, 0, 0, 1, 0, 0);
         s      = noise(1, 0, 1, 1);
         s.cw   = 1'b1;
         m_fill = (m_fill + 1) % m_nb;
         if (r == rows - 1) begin
            push(s, 0, 0, 0, 0, 1, 1, 0);
            push(noise(1, 1, 1, 0), 0, 0, 0, 0, 0, 0, 0);
         end else begin
            push(s, 1, 0, 0, 0, 1, 0, 0);
         end
      end
   endtask

   task automatic run_q(input int sel, input string name);
      logic [10:0] o;
      for (int i = 0; i < stim_q.size(); i++) begin
         @(negedge clk);
         drive(sel, stim_q[i]);
         if (stim_q[i].rst) begin
            rst = 1'b1;
            #1;
            check_eq($sformatf("%s_rst[%0d]", name, i), 32'(obs_vec(sel)), 32'(exp_vec(exp_q[i])));
            @(posedge clk);
            #1;
            rst = 1'b0;
         end else begin
            @(posedge clk);
            #1;
            o = obs_vec(sel);
            if (sel == 1 && o[7]) n_sw4++;
            check_eq($sformatf("%s[%0d]", name, i), 32'(o), 32'(exp_vec(exp_q[i])));
         end
      end
      stim_q.delete();
      exp_q.delete();
   endtask

   initial begin
      exp_t e0;
      drive(0, '0);
      e0 = '{bc: 0, sr: 0, ec: 0, sw: 0, busy: 0, fd: 0, err: 0, fill: 0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_nb = 3;
      check_eq("reset3", 32'(obs_vec(0)), 32'(exp_vec(e0)));
      m_nb = 4;
      check_eq("reset4", 32'(obs_vec(1)), 32'(exp_vec(e0)));
      rst = 1'b0;

      m_nb = 3; m_fill = 0;
      idle(2); build_frame(4, -1, -1); idle(2);
      run_q(0, "nominal");

      build_frame(2, -1, -1); err_hold(3); push_abort(); idle(1);
      run_q(0, "short_frame");

      build_frame(4, -1, 0); err_hold(2); push_abort(); idle(1);
      run_q(0, "rd_timeout");

      build_frame(3, m_to - 1, -1); idle(1);
      run_q(0, "rd_last_cycle");

      build_frame(4, -1, -1); trunc(mark_calc2 + 1); push_abort();
      build_frame(3, -1, -1); idle(1);
      run_q(0, "abort_calc");

      build_frame(4, -1, -1); trunc(mark_write + 1); push_reset(); idle(2);
      build_frame(3, -1, -1); idle(1);
      run_q(0, "rst_write");

      repeat (8) begin
         build_frame($urandom_range(3, 7), -1, -1);
         idle($urandom_range(0, 3));
      end
      run_q(0, "rand3");

      m_nb = 4; m_fill = 0;
      idle(1); build_frame(5, -1, -1); idle(2);
      n_sw4 = 0;
      run_q(1, "nb4");
      check_eq("nb4_computed_rows", 32'(n_sw4), 32'(5 - (m_nb - 1)));

      build_frame(3, -1, -1); err_hold(1); push_abort();
      repeat (4) begin
         build_frame($urandom_range(4, 8), -1, -1);
         idle($urandom_range(0, 2));
      end
      run_q(1, "rand4");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
